// File: rtl/regfile_arbiter.sv
// Two-requester round-robin write arbiter for a small register file, plus a rate-commit FSM.
// Latency: accept in cycle N -> wr_en beat in cycle N+1; update_ok follows IDLE_CYCLES quiet UART cycles after a rate write.
// Backpressure: readies are combinational, at most one per cycle, and are forced low by freeze (the commit FSM keeps running).
module regfile_arbiter #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 2,
  parameter int IDLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_ready,
  input  logic                  freeze,
  input  logic                  uart_busy,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  grant_id,
  output logic                  update_ok,
  output logic                  rate_pending
);

  // A zero-cycle idle requirement still needs a one-bit counter to keep widths legal.
  localparam int CNT_W = (IDLE_CYCLES < 1) ? 1 : $clog2(IDLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(IDLE_CYCLES);
  localparam logic [ADDR_WIDTH-1:0] RATE_ADDR = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_IDLE,
    ST_COMMIT
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] idle_cnt, idle_cnt_nxt;
  logic             rr_ptr;     // 0: requester 0 wins a tie, 1: requester 1 wins
  logic             grant0, grant1;
  logic             acc0, acc1;
  logic             rate_hit;

  // Round-robin selection; readies held low in reset and while frozen.
  always_comb begin
    grant0     = req0_valid & (~req1_valid | ~rr_ptr);
    grant1     = req1_valid & (~req0_valid | rr_ptr);
    req0_ready = rst_n & ~freeze & grant0;
    req1_ready = rst_n & ~freeze & grant1;
    acc0       = req0_valid & req0_ready;
    acc1       = req1_valid & req1_ready;
  end

  // Register the accepted beat onto the write port and advance the pointer past the winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      grant_id <= 1'b0;
      rr_ptr   <= 1'b0;
    end else begin
      wr_en <= acc0 | acc1;
      if (acc0) begin
        wr_addr  <= req0_addr;
        wr_data  <= req0_data;
        grant_id <= 1'b0;
        rr_ptr   <= 1'b1;
      end else if (acc1) begin
        wr_addr  <= req1_addr;
        wr_data  <= req1_data;
        grant_id <= 1'b1;
        rr_ptr   <= 1'b0;
      end
    end
  end

  // Commit FSM state and idle counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      idle_cnt <= '0;
    end else begin
      state    <= state_nxt;
      idle_cnt <= idle_cnt_nxt;
    end
  end

  // Next-state logic: the move to COMMIT happens on the edge where the counter reaches its target,
  // so COMMIT lands exactly IDLE_CYCLES quiet cycles after the rate write.
  always_comb begin
    state_nxt    = state;
    idle_cnt_nxt = idle_cnt;
    rate_hit     = wr_en && (wr_addr == RATE_ADDR);
    update_ok    = (state == ST_COMMIT);
    rate_pending = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (rate_hit) begin
          state_nxt    = ST_WAIT_IDLE;
          idle_cnt_nxt = '0;
        end
      end
      ST_WAIT_IDLE: begin
        if (rate_hit || uart_busy) begin
          idle_cnt_nxt = '0;
        end else if (idle_cnt != CNT_MAX) begin
          idle_cnt_nxt = idle_cnt + CNT_W'(1);
        end
        if (idle_cnt_nxt == CNT_MAX) begin
          state_nxt = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        // A rate write landing on the commit beat gets its own, later commit.
        idle_cnt_nxt = '0;
        state_nxt    = rate_hit ? ST_WAIT_IDLE : ST_IDLE;
      end
      default: begin
        state_nxt    = ST_IDLE;
        idle_cnt_nxt = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter: a vector table for arbitration/freeze/hold behaviour,
// then hand-written sequences for rate commit timing, busy restart, commit overlap and reset abort.
// Inputs change 1ns after a rising edge; outputs are sampled 2ns later, well before the next edge.
module tb_regfile_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic [1:0]  req0_addr, req1_addr;
  logic [15:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        freeze, uart_busy;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [15:0] wr_data;
  logic        grant_id, update_ok, rate_pending;

  int checks = 0;
  int errors = 0;

  regfile_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(2), .IDLE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .freeze(freeze), .uart_busy(uart_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .grant_id(grant_id),
    .update_ok(update_ok), .rate_pending(rate_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v0;
    logic [1:0]  a0;
    logic [15:0] d0;
    logic        v1;
    logic [1:0]  a1;
    logic [15:0] d1;
    logic        frz;
    logic        r0;
    logic        r1;
    logic        we;
    logic [1:0]  wa;
    logic [15:0] wd;
    logic        gid;
  } vec_t;

  vec_t tbl[14];

  function automatic vec_t mk(logic v0, logic [1:0] a0, logic [15:0] d0,
                              logic v1, logic [1:0] a1, logic [15:0] d1, logic frz,
                              logic r0, logic r1, logic we, logic [1:0] wa,
                              logic [15:0] wd, logic gid);
    vec_t v;
    v.v0 = v0; v.a0 = a0; v.d0 = d0;
    v.v1 = v1; v.a1 = a1; v.d1 = d1; v.frz = frz;
    v.r0 = r0; v.r1 = r1; v.we = we; v.wa = wa; v.wd = wd; v.gid = gid;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " wr_en"},        32'(wr_en),        32'd0);
    chk({tag, " wr_addr"},      32'(wr_addr),      32'd0);
    chk({tag, " wr_data"},      32'(wr_data),      32'd0);
    chk({tag, " grant_id"},     32'(grant_id),     32'd0);
    chk({tag, " update_ok"},    32'(update_ok),    32'd0);
    chk({tag, " rate_pending"}, 32'(rate_pending), 32'd0);
    chk({tag, " req0_ready"},   32'(req0_ready),   32'd0);
    chk({tag, " req1_ready"},   32'(req1_ready),   32'd0);
  endtask

  // Offer one requester-0 write to the rate register and step to its wr_en beat.
  task automatic rate_write(input logic [15:0] data);
    req0_valid = 1'b1; req0_addr = 2'd1; req0_data = data;
    #1;
    chk("rate_write ready0", 32'(req0_ready), 32'd1);
    tick();
    req0_valid = 1'b0;
    chk("rate_write wr_en",   32'(wr_en),   32'd1);
    chk("rate_write wr_addr", 32'(wr_addr), 32'd1);
    chk("rate_write wr_data", 32'(wr_data), 32'(data));
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_addr = 2'd0; req0_data = 16'h0001;
    req1_valid = 1'b1; req1_addr = 2'd2; req1_data = 16'h0004;
    freeze = 1'b0; uart_busy = 1'b0;

    // Arbitration table (busy=0). Outputs are those of the cycle the inputs are applied in.
    tbl[0]  = mk(1, 0, 16'h0001, 1, 2, 16'h0004, 0,  1, 0,  0, 0, 16'h0000, 0);
    tbl[1]  = mk(1, 0, 16'h0001, 1, 2, 16'h0004, 0,  0, 1,  1, 0, 16'h0001, 0);
    tbl[2]  = mk(1, 0, 16'h0001, 1, 2, 16'h0004, 0,  1, 0,  1, 2, 16'h0004, 1);
    tbl[3]  = mk(1, 0, 16'h0001, 1, 2, 16'h0004, 0,  0, 1,  1, 0, 16'h0001, 0);
    tbl[4]  = mk(1, 0, 16'h0001, 1, 2, 16'h0004, 1,  0, 0,  1, 2, 16'h0004, 1);
    tbl[5]  = mk(1, 0, 16'h0001, 1, 2, 16'h0004, 1,  0, 0,  0, 2, 16'h0004, 1);
    tbl[6]  = mk(1, 0, 16'h0001, 1, 2, 16'h0004, 1,  0, 0,  0, 2, 16'h0004, 1);
    tbl[7]  = mk(1, 0, 16'h0001, 1, 2, 16'h0004, 0,  1, 0,  0, 2, 16'h0004, 1);
    tbl[8]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0,  0, 0,  1, 0, 16'h0001, 0);
    tbl[9]  = mk(0, 0, 16'h0000, 1, 3, 16'hBEEF, 0,  0, 1,  0, 0, 16'h0001, 0);
    tbl[10] = mk(0, 0, 16'h0000, 1, 3, 16'h1234, 0,  0, 1,  1, 3, 16'hBEEF, 1);
    tbl[11] = mk(1, 0, 16'h00AA, 0, 0, 16'h0000, 0,  1, 0,  1, 3, 16'h1234, 1);
    tbl[12] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0,  0, 0,  1, 0, 16'h00AA, 0);
    tbl[13] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0,  0, 0,  0, 0, 16'h00AA, 0);

    // Reset state with both requesters valid: everything low, including readies.
    #3;
    check_all_zero("reset");
    tick();
    check_all_zero("reset_edge");

    // Release between edges; the first table vector must be accepted on the very next edge.
    rst_n = 1'b1;
    for (int i = 0; i < 14; i++) begin
      req0_valid = tbl[i].v0; req0_addr = tbl[i].a0; req0_data = tbl[i].d0;
      req1_valid = tbl[i].v1; req1_addr = tbl[i].a1; req1_data = tbl[i].d1;
      freeze     = tbl[i].frz;
      #1;
      chk($sformatf("vec%0d req0_ready", i),   32'(req0_ready),   32'(tbl[i].r0));
      chk($sformatf("vec%0d req1_ready", i),   32'(req1_ready),   32'(tbl[i].r1));
      chk($sformatf("vec%0d wr_en", i),        32'(wr_en),        32'(tbl[i].we));
      chk($sformatf("vec%0d wr_addr", i),      32'(wr_addr),      32'(tbl[i].wa));
      chk($sformatf("vec%0d wr_data", i),      32'(wr_data),      32'(tbl[i].wd));
      chk($sformatf("vec%0d grant_id", i),     32'(grant_id),     32'(tbl[i].gid));
      chk($sformatf("vec%0d update_ok", i),    32'(update_ok),    32'd0);
      chk($sformatf("vec%0d rate_pending", i), 32'(rate_pending), 32'd0);
      tick();
    end
    freeze = 1'b0;

    // Rate write with UART quiet: pending from the next cycle, commit 5 cycles after the beat.
    rate_write(16'h4B00);
    chk("rate beat rate_pending", 32'(rate_pending), 32'd0);
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk($sformatf("rate k%0d update_ok", k),    32'(update_ok),    32'(k == 5));
      chk($sformatf("rate k%0d rate_pending", k), 32'(rate_pending), 32'(k <= 5));
    end

    // Busy on the 3rd and 4th quiet cycles restarts the count; commit 4 quiet cycles after busy drops.
    rate_write(16'h2580);
    for (int k = 1; k <= 10; k++) begin
      tick();
      uart_busy = (k == 3 || k == 4);
      chk($sformatf("busy k%0d update_ok", k),    32'(update_ok),    32'(k == 9));
      chk($sformatf("busy k%0d rate_pending", k), 32'(rate_pending), 32'(k <= 9));
    end
    uart_busy = 1'b0;

    // Second rate write lands on the commit beat: pulse completes, pending stays, second commit follows.
    rate_write(16'h1C20);
    for (int k = 1; k <= 11; k++) begin
      tick();
      req0_valid = (k == 4); req0_addr = 2'd1; req0_data = 16'h9600;
      if (k == 5) begin
        chk("overlap wr_en", 32'(wr_en), 32'd1);
      end
      chk($sformatf("overlap k%0d update_ok", k),    32'(update_ok),    32'(k == 5 || k == 10));
      chk($sformatf("overlap k%0d rate_pending", k), 32'(rate_pending), 32'(k <= 10));
    end
    req0_valid = 1'b0;

    // Reset in WAIT_IDLE drops everything at once and no commit follows.
    rate_write(16'h4B00);
    tick();
    tick();
    chk("abort pre rate_pending", 32'(rate_pending), 32'd1);
    req0_valid = 1'b1; req0_addr = 2'd0; req0_data = 16'h0001;
    req1_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    check_all_zero("abort");
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("abort k%0d update_ok", k),    32'(update_ok),    32'd0);
      chk($sformatf("abort k%0d rate_pending", k), 32'(rate_pending), 32'd0);
    end

    // Pointer returned to requester 0 by reset.
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("post_reset req0_ready", 32'(req0_ready), 32'd1);
    chk("post_reset req1_ready", 32'(req1_ready), 32'd0);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("post_reset wr_en",    32'(wr_en),    32'd1);
    chk("post_reset grant_id", 32'(grant_id), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
